// File: rtl/ex_unit_mc_if.sv
// Operand/result handshake bundle between operand fetch, the execute unit and MEM.
// The execute unit takes the slave modport; the upstream/downstream driver takes master.
interface ex_unit_mc_if #(
    parameter int XLEN      = 32,
    parameter int REG_IDX_W = 5
);
    logic                 in_valid;
    logic                 in_ready;
    logic [3:0]           op_in;
    logic                 rdE_in;
    logic [REG_IDX_W-1:0] rdIdx_in;
    logic [XLEN-1:0]      a_in;
    logic [XLEN-1:0]      b_in;
    logic                 out_valid;
    logic                 out_ready;
    logic                 rdE_out;
    logic [REG_IDX_W-1:0] rdIdx_out;
    logic [XLEN-1:0]      rdData_out;

    modport master (
        output in_valid, op_in, rdE_in, rdIdx_in, a_in, b_in, out_ready,
        input  in_ready, out_valid, rdE_out, rdIdx_out, rdData_out
    );

    modport slave (
        input  in_valid, op_in, rdE_in, rdIdx_in, a_in, b_in, out_ready,
        output in_ready, out_valid, rdE_out, rdIdx_out, rdData_out
    );
endinterface

// File: rtl/ex_unit_mc.sv
// Registered execute stage: single-cycle integer ALU plus iterative multiply/divide.
// Define EX_MULDIV_EN to build the multi-cycle MUL/MULHU/DIVU/REMU datapath; otherwise opcodes 12-15 act as NOPs.
module ex_unit_mc #(
    parameter int XLEN      = 32,
    parameter int REG_IDX_W = 5
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        flush_in,
    ex_unit_mc_if.slave bus,
    output logic        busy_out
);
    localparam int SHAMT_W = $clog2(XLEN);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_SLL   = 4'd2;
    localparam logic [3:0] OP_SLT   = 4'd3;
    localparam logic [3:0] OP_SLTU  = 4'd4;
    localparam logic [3:0] OP_XOR   = 4'd5;
    localparam logic [3:0] OP_SRL   = 4'd6;
    localparam logic [3:0] OP_SRA   = 4'd7;
    localparam logic [3:0] OP_OR    = 4'd8;
    localparam logic [3:0] OP_AND   = 4'd9;
    localparam logic [3:0] OP_LUI   = 4'd10;
    localparam logic [3:0] OP_AUIPC = 4'd11;

    logic [SHAMT_W-1:0]   shamt;
    logic [XLEN-1:0]      alu_res;
    logic                 is_muldiv;
    logic                 idle;
    logic                 accept;

    logic                 out_valid_q, out_valid_d;
    logic                 rd_e_out_q, rd_e_out_d;
    logic [REG_IDX_W-1:0] rd_idx_out_q, rd_idx_out_d;
    logic [XLEN-1:0]      rd_data_out_q, rd_data_out_d;

    assign shamt          = bus.b_in[SHAMT_W-1:0];
    assign is_muldiv      = bus.op_in[3] & bus.op_in[2];
    assign bus.in_ready   = idle && !flush_in && (!out_valid_q || bus.out_ready);
    assign accept         = bus.in_valid && bus.in_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.rdE_out    = rd_e_out_q;
    assign bus.rdIdx_out  = rd_idx_out_q;
    assign bus.rdData_out = rd_data_out_q;

    // Single-cycle ALU; opcodes 12-15 fall to zero here and are handled by the mul/div path.
    always_comb begin
        alu_res = '0;
        case (bus.op_in)
            OP_ADD, OP_AUIPC: alu_res = bus.a_in + bus.b_in;
            OP_SUB:           alu_res = bus.a_in - bus.b_in;
            OP_SLL:           alu_res = bus.a_in << shamt;
            OP_SLT:           alu_res = {{(XLEN-1){1'b0}}, $signed(bus.a_in) < $signed(bus.b_in)};
            OP_SLTU:          alu_res = {{(XLEN-1){1'b0}}, bus.a_in < bus.b_in};
            OP_XOR:           alu_res = bus.a_in ^ bus.b_in;
            OP_SRL:           alu_res = bus.a_in >> shamt;
            OP_SRA:           alu_res = $unsigned($signed(bus.a_in) >>> shamt);
            OP_OR:            alu_res = bus.a_in | bus.b_in;
            OP_AND:           alu_res = bus.a_in & bus.b_in;
            OP_LUI:           alu_res = bus.b_in;
            default:          alu_res = '0;
        endcase
    end

`ifdef EX_MULDIV_EN
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t               state_q, state_d;
    logic [SHAMT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]           md_op_q, md_op_d;
    logic [XLEN-1:0]      opnd_q, opnd_d;
    logic [2*XLEN-1:0]    acc_q, acc_d;
    logic                 md_rd_e_q, md_rd_e_d;
    logic [REG_IDX_W-1:0] md_rd_idx_q, md_rd_idx_d;

    logic [XLEN:0]        mul_sum;
    logic [XLEN:0]        div_shift;
    logic [XLEN-1:0]      div_diff;
    logic                 div_ge;
    logic [XLEN-1:0]      md_res;

    assign idle     = (state_q == IDLE);
    assign busy_out = (state_q == BUSY);

    // acc = {hi, lo}: multiply keeps the multiplier in lo and the partial product in hi;
    // divide keeps the dividend/quotient in lo and the partial remainder in hi.
    // A zero divisor makes every trial subtract succeed, giving all-ones quotient and remainder = a.
    assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
    assign div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    assign div_ge    = (div_shift >= {1'b0, opnd_q});
    assign div_diff  = div_shift[XLEN-1:0] - opnd_q;

    always_comb begin
        md_res = acc_q[XLEN-1:0];
        case (md_op_q)
            2'd0: md_res = acc_q[XLEN-1:0];
            2'd1: md_res = acc_q[2*XLEN-1:XLEN];
            2'd2: md_res = acc_q[XLEN-1:0];
            2'd3: md_res = acc_q[2*XLEN-1:XLEN];
            default: md_res = acc_q[XLEN-1:0];
        endcase
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        md_op_d       = md_op_q;
        opnd_d        = opnd_q;
        acc_d         = acc_q;
        md_rd_e_d     = md_rd_e_q;
        md_rd_idx_d   = md_rd_idx_q;
        out_valid_d   = out_valid_q && !bus.out_ready;
        rd_e_out_d    = rd_e_out_q;
        rd_idx_out_d  = rd_idx_out_q;
        rd_data_out_d = rd_data_out_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (is_muldiv) begin
                        state_d     = BUSY;
                        cnt_d       = '0;
                        md_op_d     = bus.op_in[1:0];
                        md_rd_e_d   = bus.rdE_in;
                        md_rd_idx_d = bus.rdIdx_in;
                        opnd_d      = bus.op_in[1] ? bus.b_in : bus.a_in;
                        acc_d       = {{XLEN{1'b0}}, (bus.op_in[1] ? bus.a_in : bus.b_in)};
                    end else begin
                        out_valid_d   = 1'b1;
                        rd_e_out_d    = bus.rdE_in;
                        rd_idx_out_d  = bus.rdIdx_in;
                        rd_data_out_d = alu_res;
                    end
                end
            end
            BUSY: begin
                acc_d = md_op_q[1] ? {(div_ge ? div_diff : div_shift[XLEN-1:0]), acc_q[XLEN-2:0], div_ge}
                                   : {mul_sum, acc_q[XLEN-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == SHAMT_W'(XLEN-1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (!out_valid_q || bus.out_ready) begin
                    out_valid_d   = 1'b1;
                    rd_e_out_d    = md_rd_e_q;
                    rd_idx_out_d  = md_rd_idx_q;
                    rd_data_out_d = md_res;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (flush_in) begin
            out_valid_d = 1'b0;
            rd_e_out_d  = 1'b0;
            state_d     = IDLE;
            cnt_d       = '0;
        end
    end
`else
    assign idle     = 1'b1;
    assign busy_out = 1'b0;

    always_comb begin
        out_valid_d   = out_valid_q && !bus.out_ready;
        rd_e_out_d    = rd_e_out_q;
        rd_idx_out_d  = rd_idx_out_q;
        rd_data_out_d = rd_data_out_q;
        if (accept) begin
            out_valid_d   = 1'b1;
            rd_e_out_d    = bus.rdE_in && !is_muldiv;
            rd_idx_out_d  = bus.rdIdx_in;
            rd_data_out_d = alu_res;
        end
        if (flush_in) begin
            out_valid_d = 1'b0;
            rd_e_out_d  = 1'b0;
        end
    end
`endif

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            out_valid_q   <= 1'b0;
            rd_e_out_q    <= 1'b0;
            rd_idx_out_q  <= '0;
            rd_data_out_q <= '0;
`ifdef EX_MULDIV_EN
            state_q       <= IDLE;
            cnt_q         <= '0;
            md_op_q       <= '0;
            opnd_q        <= '0;
            acc_q         <= '0;
            md_rd_e_q     <= 1'b0;
            md_rd_idx_q   <= '0;
`endif
        end else begin
            out_valid_q   <= out_valid_d;
            rd_e_out_q    <= rd_e_out_d;
            rd_idx_out_q  <= rd_idx_out_d;
            rd_data_out_q <= rd_data_out_d;
`ifdef EX_MULDIV_EN
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            md_op_q       <= md_op_d;
            opnd_q        <= opnd_d;
            acc_q         <= acc_d;
            md_rd_e_q     <= md_rd_e_d;
            md_rd_idx_q   <= md_rd_idx_d;
`endif
        end
    end
endmodule

// File: tb/tb_ex_unit_mc.sv
// Directed self-checking bench for ex_unit_mc: ALU results, streaming, backpressure, reset, flush.
// The EX_MULDIV_EN build additionally checks mul/div results, latency and flush during BUSY.
module tb_ex_unit_mc;
    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;
    localparam int NV        = 12;

    logic clk_in   = 1'b0;
    logic rst_in   = 1'b1;
    logic flush_in = 1'b0;
    logic busy_out;

    int n_checks = 0;
    int n_fails  = 0;

    ex_unit_mc_if #(.XLEN(XLEN), .REG_IDX_W(REG_IDX_W)) bus ();

    ex_unit_mc #(.XLEN(XLEN), .REG_IDX_W(REG_IDX_W)) dut (
        .clk_in   (clk_in),
        .rst_in   (rst_in),
        .flush_in (flush_in),
        .bus      (bus),
        .busy_out (busy_out)
    );

    always #5 clk_in = ~clk_in;

    // Streamed single-cycle vectors with hand-computed results.
    logic [3:0]  v_op [NV] = '{4'd0, 4'd7, 4'd3, 4'd4, 4'd1, 4'd2, 4'd6, 4'd5, 4'd8, 4'd9, 4'd10, 4'd11};
    logic [31:0] v_a  [NV] = '{32'hFFFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5, 32'd1,
                               32'h80000000, 32'hF0F0F0F0, 32'h00FF0000, 32'h12345678, 32'h0000DEAD, 32'h00001000};
    logic [31:0] v_b  [NV] = '{32'd1, 32'h21, 32'd0, 32'd0, 32'd7, 32'h24,
                               32'h3F, 32'hFF00FF00, 32'h0000FF00, 32'h0F0F0F0F, 32'h12345000, 32'h00002000};
    logic [31:0] v_exp[NV] = '{32'h0, 32'hC0000000, 32'd1, 32'd0, 32'hFFFFFFFE, 32'h10,
                               32'd1, 32'h0FF00FF0, 32'h00FFFF00, 32'h02040608, 32'h12345000, 32'h00003000};

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] idx);
        bus.in_valid = 1'b1;
        bus.op_in    = op;
        bus.rdE_in   = 1'b1;
        bus.rdIdx_in = idx;
        bus.a_in     = a;
        bus.b_in     = b;
    endtask

`ifdef EX_MULDIV_EN
    task automatic runMulDiv(input string tag, input logic [3:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] expected);
        int lat;
        int busy_cnt;
        applyStimulus(op, a, b, 5'd9);
        #1;
        checkOutput({tag, "_accept"}, 64'(bus.in_ready), 64'd1);
        tick();
        bus.in_valid = 1'b0;
        lat      = 0;
        busy_cnt = 0;
        while (!bus.out_valid && lat < 100) begin
            if (busy_out) busy_cnt++;
            tick();
            lat++;
        end
        checkOutput({tag, "_latency"}, 64'(lat), 64'd33);
        checkOutput({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd32);
        checkOutput({tag, "_data"}, 64'(bus.rdData_out), 64'(expected));
        checkOutput({tag, "_idx"}, 64'(bus.rdIdx_out), 64'd9);
        checkOutput({tag, "_rde"}, 64'(bus.rdE_out), 64'd1);
        tick();
    endtask
`endif

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.in_valid  = 1'b0;
        bus.op_in     = '0;
        bus.rdE_in    = 1'b0;
        bus.rdIdx_in  = '0;
        bus.a_in      = '0;
        bus.b_in      = '0;
        bus.out_ready = 1'b1;

        // Power-on reset
        #2 rst_in = 1'b0;
        #10;
        checkOutput("rst_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("rst_rde", 64'(bus.rdE_out), 64'd0);
        checkOutput("rst_idx", 64'(bus.rdIdx_out), 64'd0);
        checkOutput("rst_data", 64'(bus.rdData_out), 64'd0);
        checkOutput("rst_busy", 64'(busy_out), 64'd0);
        #1 rst_in = 1'b1;
        tick();
        checkOutput("rst_release_ready", 64'(bus.in_ready), 64'd1);

        // Back-to-back single-cycle stream, one result per cycle
        for (int i = 0; i < NV; i++) begin
            applyStimulus(v_op[i], v_a[i], v_b[i], 5'(i + 1));
            tick();
            checkOutput($sformatf("alu%0d_valid", i), 64'(bus.out_valid), 64'd1);
            checkOutput($sformatf("alu%0d_data", i), 64'(bus.rdData_out), 64'(v_exp[i]));
            checkOutput($sformatf("alu%0d_idx", i), 64'(bus.rdIdx_out), 64'(i + 1));
        end
        bus.in_valid = 1'b0;
        tick();
        checkOutput("drain_valid", 64'(bus.out_valid), 64'd0);

        // Backpressure holds the result and blocks acceptance
        applyStimulus(4'd0, 32'd3, 32'd4, 5'd3);
        tick();
        checkOutput("bp_first_data", 64'(bus.rdData_out), 64'd7);
        bus.out_ready = 1'b0;
        applyStimulus(4'd1, 32'd20, 32'd3, 5'd4);
        #1;
        checkOutput("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
        tick();
        checkOutput("bp_hold_valid", 64'(bus.out_valid), 64'd1);
        checkOutput("bp_hold_data", 64'(bus.rdData_out), 64'd7);
        tick();
        checkOutput("bp_hold_data2", 64'(bus.rdData_out), 64'd7);
        checkOutput("bp_hold_idx", 64'(bus.rdIdx_out), 64'd3);
        bus.out_ready = 1'b1;
        #1;
        checkOutput("bp_in_ready_high", 64'(bus.in_ready), 64'd1);
        tick();
        checkOutput("bp_release_data", 64'(bus.rdData_out), 64'h11);
        checkOutput("bp_release_idx", 64'(bus.rdIdx_out), 64'd4);
        bus.in_valid = 1'b0;

        // Asynchronous reset while a result is held
        bus.out_ready = 1'b0;
        #2 rst_in = 1'b0;
        #1;
        checkOutput("async_rst_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("async_rst_data", 64'(bus.rdData_out), 64'd0);
        checkOutput("async_rst_idx", 64'(bus.rdIdx_out), 64'd0);
        checkOutput("async_rst_rde", 64'(bus.rdE_out), 64'd0);
        #1 rst_in = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        checkOutput("async_rst_ready", 64'(bus.in_ready), 64'd1);

        // Flush drops a held result; the op offered with flush is not taken
        applyStimulus(4'd8, 32'hF0, 32'h0F, 5'd6);
        tick();
        checkOutput("fl_pre_data", 64'(bus.rdData_out), 64'hFF);
        bus.out_ready = 1'b0;
        flush_in      = 1'b1;
        applyStimulus(4'd0, 32'd1, 32'd1, 5'd7);
        #1;
        checkOutput("fl_in_ready", 64'(bus.in_ready), 64'd0);
        tick();
        checkOutput("fl_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("fl_rde", 64'(bus.rdE_out), 64'd0);
        flush_in      = 1'b0;
        bus.out_ready = 1'b1;
        #1;
        checkOutput("fl_next_ready", 64'(bus.in_ready), 64'd1);
        tick();
        checkOutput("fl_next_valid", 64'(bus.out_valid), 64'd1);
        checkOutput("fl_next_data", 64'(bus.rdData_out), 64'd2);
        checkOutput("fl_next_idx", 64'(bus.rdIdx_out), 64'd7);
        bus.in_valid = 1'b0;
        tick();

`ifdef EX_MULDIV_EN
        runMulDiv("mul", 4'd12, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFE);
        runMulDiv("mulhu", 4'd13, 32'hFFFFFFFF, 32'd2, 32'h00000001);
        runMulDiv("mul_zero", 4'd12, 32'h0, 32'h12345678, 32'h0);
        runMulDiv("divu", 4'd14, 32'd100, 32'd7, 32'd14);
        runMulDiv("remu", 4'd15, 32'd100, 32'd7, 32'd2);
        runMulDiv("divu_by0", 4'd14, 32'd100, 32'd0, 32'hFFFFFFFF);
        runMulDiv("remu_by0", 4'd15, 32'd100, 32'd0, 32'd100);

        // Flush at iteration 10 discards the multiply
        begin
            int seen;
            applyStimulus(4'd12, 32'd3, 32'd5, 5'd10);
            tick();
            bus.in_valid = 1'b0;
            repeat (10) tick();
            checkOutput("flb_busy_before", 64'(busy_out), 64'd1);
            flush_in = 1'b1;
            applyStimulus(4'd0, 32'd2, 32'd3, 5'd11);
            #1;
            checkOutput("flb_in_ready", 64'(bus.in_ready), 64'd0);
            tick();
            checkOutput("flb_busy_after", 64'(busy_out), 64'd0);
            checkOutput("flb_out_valid", 64'(bus.out_valid), 64'd0);
            flush_in = 1'b0;
            #1;
            checkOutput("flb_next_ready", 64'(bus.in_ready), 64'd1);
            tick();
            checkOutput("flb_next_valid", 64'(bus.out_valid), 64'd1);
            checkOutput("flb_next_data", 64'(bus.rdData_out), 64'd5);
            checkOutput("flb_next_idx", 64'(bus.rdIdx_out), 64'd11);
            bus.in_valid = 1'b0;
            seen = 0;
            repeat (40) begin
                tick();
                if (bus.out_valid) seen = 1;
            end
            checkOutput("flb_no_result", 64'(seen), 64'd0);
        end
`else
        // Without the mul/div datapath, opcodes 12-15 complete as single-cycle NOPs
        for (int op = 12; op < 16; op++) begin
            applyStimulus(4'(op), 32'd100, 32'd7, 5'd12);
            tick();
            checkOutput($sformatf("nop%0d_valid", op), 64'(bus.out_valid), 64'd1);
            checkOutput($sformatf("nop%0d_data", op), 64'(bus.rdData_out), 64'd0);
            checkOutput($sformatf("nop%0d_rde", op), 64'(bus.rdE_out), 64'd0);
            checkOutput($sformatf("nop%0d_busy", op), 64'(busy_out), 64'd0);
        end
        bus.in_valid = 1'b0;
        tick();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/ex_unit_mc.md
Name: ex_unit_mc

Overview:
- Parametrised, registered successor to the single-cycle execute stage.
- Performs the base integer ALU ops in one cycle, plus iterative multiply/divide over XLEN cycles.
- Sits between decode/operand fetch and the MEM stage, with valid/ready handshakes on both sides.
- Holds the result in an output register until MEM accepts it; pipeline flush supported.

Parameters:
- XLEN, 32: datapath width; must be a power of two, at least 8.
- REG_IDX_W, 5: destination register index width.
- SHAMT_W, $clog2(XLEN): localparam; shift-amount width taken from the low bits of b_in.

Ports:
- clk_in  in  1  clock; all state updates on the rising edge.
- rst_in  in  1  asynchronous, active-low reset.
- flush_in  in  1  discard the in-flight op and the output register.
- in_valid  in  1  op/operands valid.
- in_ready  out  1  unit can accept an op this cycle.
- op_in  in  4  operation code (see Behaviour).
- rdE_in  in  1  destination write enable.
- rdIdx_in  in  REG_IDX_W  destination register index.
- a_in  in  XLEN  operand A (rs1 or pc).
- b_in  in  XLEN  operand B (rs2 or imm).
- out_valid  out  1  result register valid.
- out_ready  in  1  MEM accepts the result.
- rdE_out  out  1  registered write enable.
- rdIdx_out  out  REG_IDX_W  registered destination index.
- rdData_out  out  XLEN  registered result.
- busy_out  out  1  multi-cycle op in progress.

Behaviour:
- Opcodes:
  - 0 ADD, 1 SUB (a-b), 2 SLL, 3 SLT (signed), 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND.
  - 10 LUI (result = b), 11 AUIPC (result = a+b).
  - 12 MUL (low XLEN bits), 13 MULHU (high XLEN bits, unsigned), 14 DIVU, 15 REMU.
- Arithmetic rules:
  - Add/sub wrap modulo 2^XLEN.
  - SLT/SLTU produce 0 or 1, zero-extended.
  - Shifts use b[SHAMT_W-1:0] only.
- Reset (rst_in low, asynchronous): state IDLE; out_valid=0, rdE_out=0, rdIdx_out=0, rdData_out=0, busy_out=0, counter=0.
- Acceptance: in_ready = (state==IDLE) && !flush_in && (!out_valid || out_ready). An op is accepted when in_valid && in_ready.
- States:
  - IDLE:
    - Single-cycle op accepted at edge T → output register loaded; out_valid=1 after edge T (latency 1).
    - Mul/div op accepted → go to BUSY. Latch operands, rdE, rdIdx and op; counter=0.
  - BUSY:
    - One iteration per cycle: shift-add multiply (2*XLEN-bit accumulator) or restoring divide (one quotient bit per cycle).
    - busy_out=1. Counter increments each cycle.
    - When counter==XLEN-1, the final iteration is performed and the state moves to DONE.
  - DONE:
    - Load the output register (if !out_valid || out_ready), set out_valid, go to IDLE. Otherwise remain in DONE.
    - With out_ready held high, a mul/div accepted at edge T gives out_valid high after edge T+XLEN+1.
- Output register: holds its value while out_valid && !out_ready. Cleared (out_valid=0) on out_ready unless reloaded in the same cycle.
- Back-to-back: with out_ready held high, one single-cycle op is accepted per cycle, at full throughput.
- Divide by zero (DIVU/REMU): quotient = all ones, remainder = a. The iteration count is unchanged.
- MUL/MULHU with either operand 0: result 0, still takes the full latency.
- Flush:
  - On the next edge: out_valid=0, state=IDLE, counter=0, busy_out=0. rdE_out is forced to 0.
  - An op presented in the same cycle as flush_in is not accepted.
- Reset mid-operation: asynchronous return to the reset values; the partial result is discarded.
- rdE_out/rdIdx_out pass through from the accepted op unchanged. rdE_out is meaningful only while out_valid=1.

Optional Feature:
- Macro: EX_MULDIV_EN.
- Defined: opcodes 12-15 operate as above.
- Undefined:
  - BUSY/DONE datapath not built; busy_out tied 0.
  - Opcodes 12-15 complete in one cycle with rdData_out=0 and rdE_out=0 (treated as NOP).

Test Plan:
- Reset with rst_in=0 mid-run → all outputs 0 asynchronously, before the next clock edge. Release → in_ready=1.
- ADD a=0xFFFFFFFF, b=1 → out_valid next cycle, rdData_out=0x00000000. SRA a=0x80000000, b=0x21 (shamt 1) → 0xC0000000. SLT a=0xFFFFFFFF, b=0 → 1; SLTU with the same operands → 0.
- Stream 4 ops (ADD, XOR, LUI b=0x12345000, AUIPC a=0x1000 b=0x2000) with out_ready=1 → 4 results on 4 consecutive cycles; LUI gives 0x12345000, AUIPC gives 0x00003000.
- Backpressure: out_ready=0 after one result → rdData_out held stable, in_ready=0. Release → next op accepted.
- (EX_MULDIV_EN) Cover the mul/div results:
  - MUL 0xFFFFFFFF×2 → 0xFFFFFFFE; MULHU same operands → 0x00000001.
  - DIVU 100/7 → 14; REMU 100/7 → 2; DIVU by 0 → 0xFFFFFFFF.
  - Each out_valid exactly 33 cycles after acceptance; busy_out high for 32 of them.
- Flush during BUSY at iteration 10 → no result emitted, busy_out=0 next cycle. An ADD presented in the flush cycle is not accepted; an ADD presented the following cycle is accepted.
